// File: rtl/cache_types_pkg.sv
// Shared defaults and types for the tree-PLRU replacement array.
package cache_types;

  localparam int PLRU_WAYS = 4;
  localparam int PLRU_SETS = 16;

  // One set's tree bits, heap order, bit i = node i (node 0 = root).
  typedef logic [PLRU_WAYS-2:0] plru_bits_t;

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational tree-PLRU helper for a single set: victim walk of the
// given tree bits, and the tree bits after marking `way` most recently used.
module plru_tree_logic #(
  parameter int WAYS = 4,
  localparam int WL = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] bits,
  input  logic [WL-1:0]   way,
  output logic [WL-1:0]   victim,
  output logic [WAYS-2:0] bits_upd
);

  // Walk from the root: a 0 bit steps to the left child, a 1 bit to the right.
  always_comb begin
    int node;
    logic [WAYS-2:0] bits_sh;
    node = 0;
    bits_sh = '0;
    for (int l = 0; l < WL; l++) begin
      bits_sh = bits >> node;
      node = 2 * node + 1 + (bits_sh[0] ? 1 : 0);
    end
    victim = WL'(node - (WAYS - 1));
  end

  // Point every node on the path to `way` away from it; off-path nodes keep their value.
  always_comb begin
    int idx;
    logic [WL-1:0]   way_sh;
    logic [WAYS-2:0] one_hot;
    bits_upd = bits;
    idx = 0;
    way_sh = '0;
    one_hot = '0;
    for (int l = 0; l < WL; l++) begin
      // Node at depth l on the path: first node of that level plus the way's
      // top l bits; the next way bit says which child the path takes.
      idx = (1 << l) - 1 + (int'(way) >> (WL - l));
      way_sh = way >> (WL - 1 - l);
      one_hot = '0;
      one_hot[0] = 1'b1;
      one_hot = one_hot << idx;
      if (way_sh[0]) bits_upd = bits_upd & ~one_hot;  // way on the right -> point left
      else           bits_upd = bits_upd | one_hot;   // way on the left  -> point right
    end
  end

endmodule

// File: rtl/cache_plru_array.sv
// Tree pseudo-LRU replacement state for a set-associative cache.
// Hit (touch) and install (fill) updates, 1-cycle registered victim lookup
// that prefers the lowest invalid way.
// Optional macro PLRU_FWD_EN: a lookup sees same-cycle touch/fill updates
// to its set; without it the lookup sees the state before those updates.
module cache_plru_array
  import cache_types::*;
#(
  parameter int WAYS = PLRU_WAYS,
  parameter int SETS = PLRU_SETS,
  localparam int WL = $clog2(WAYS),
  localparam int SL = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic [SL-1:0]   lookup_set,
  input  logic [WAYS-1:0] lookup_way_valid,
  input  logic            touch_valid,
  input  logic [SL-1:0]   touch_set,
  input  logic [WL-1:0]   touch_way,
  input  logic            fill_valid,
  input  logic [SL-1:0]   fill_set,
  input  logic [WL-1:0]   fill_way,
  output logic            victim_valid,
  output logic [WL-1:0]   victim_way
);

  logic [WAYS-2:0] tree_q [SETS];

  logic [WAYS-2:0] touch_cur, touch_upd;
  logic [WAYS-2:0] fill_cur, fill_upd;
  logic [WAYS-2:0] look_cur, look_upd_unused;
  logic [WL-1:0]   touch_vic_unused, fill_vic_unused;
  logic [WL-1:0]   look_victim, vic_next;
  logic            same_set_tf;

  assign same_set_tf = touch_valid && fill_valid && (touch_set == fill_set);

  assign touch_cur = tree_q[touch_set];
  // Fill lands after the touch when both hit the same set, so it chains on
  // the touch result and ends up MRU.
  assign fill_cur  = same_set_tf ? touch_upd : tree_q[fill_set];

`ifdef PLRU_FWD_EN
  // Lookup sees the state as it will be after this cycle's updates.
  always_comb begin
    look_cur = tree_q[lookup_set];
    if (fill_valid && fill_set == lookup_set)        look_cur = fill_upd;
    else if (touch_valid && touch_set == lookup_set) look_cur = touch_upd;
  end
`else
  assign look_cur = tree_q[lookup_set];
`endif

  plru_tree_logic #(.WAYS(WAYS)) u_touch (
    .bits     (touch_cur),
    .way      (touch_way),
    .victim   (touch_vic_unused),
    .bits_upd (touch_upd)
  );

  plru_tree_logic #(.WAYS(WAYS)) u_fill (
    .bits     (fill_cur),
    .way      (fill_way),
    .victim   (fill_vic_unused),
    .bits_upd (fill_upd)
  );

  plru_tree_logic #(.WAYS(WAYS)) u_lookup (
    .bits     (look_cur),
    .way      ('0),
    .victim   (look_victim),
    .bits_upd (look_upd_unused)
  );

  // Any invalid way beats the tree: pick the lowest-index one.
  always_comb begin
    logic found;
    found = 1'b0;
    vic_next = look_victim;
    for (int i = 0; i < WAYS; i++) begin
      if (!found && !lookup_way_valid[i]) begin
        found = 1'b1;
        vic_next = WL'(i);
      end
    end
  end

  // Tree state: touch then fill; a same-set fill write carries the touch too.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else begin
      if (touch_valid) tree_q[touch_set] <= touch_upd;
      if (fill_valid)  tree_q[fill_set]  <= fill_upd;
    end
  end

  // Registered victim response; the way holds until the next lookup completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      victim_valid <= lookup_valid;
      if (lookup_valid) victim_way <= vic_next;
    end
  end

endmodule

// File: tb/tb_cache_plru_array.sv
// Bench for cache_plru_array (WAYS=4, SETS=16): directed cases then random
// traffic against a range-halving tree-PLRU reference model.
module tb_cache_plru_array;

  localparam int WAYS = 4;
  localparam int SETS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       lookup_valid;
  logic [3:0] lookup_set;
  logic [3:0] lookup_way_valid;
  logic       touch_valid;
  logic [3:0] touch_set;
  logic [1:0] touch_way;
  logic       fill_valid;
  logic [3:0] fill_set;
  logic [1:0] fill_way;
  logic       victim_valid;
  logic [1:0] victim_way;

  always #5 clk = ~clk;

  cache_plru_array #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_valid     (lookup_valid),
    .lookup_set       (lookup_set),
    .lookup_way_valid (lookup_way_valid),
    .touch_valid      (touch_valid),
    .touch_set        (touch_set),
    .touch_way        (touch_way),
    .fill_valid       (fill_valid),
    .fill_set         (fill_set),
    .fill_way         (fill_way),
    .victim_valid     (victim_valid),
    .victim_way       (victim_way)
  );

`ifdef PLRU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  // Reference: per set, one bit per internal node; walks by halving the way range.
  bit m_tree [SETS][WAYS-1];
  bit exp_vld = 1'b0;
  int exp_way = 0;

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int m_vic(int s, logic [3:0] wv);
    int lo, hi, mid, node;
    for (int i = 0; i < WAYS; i++) if (!wv[i]) return i;
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (!m_tree[s][node]) begin node = 2 * node + 1; hi = mid; end
      else                  begin node = 2 * node + 2; lo = mid; end
    end
    return lo;
  endfunction

  function automatic void m_upd(int s, int w);
    int lo, hi, mid, node;
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      m_tree[s][node] = (w < mid);  // point at the other half
      if (w < mid) begin node = 2 * node + 1; hi = mid; end
      else         begin node = 2 * node + 2; lo = mid; end
    end
  endfunction

  // One clock: drive inputs, advance the model, check outputs just after the edge.
  task automatic step(bit r, bit lv, int ls, logic [3:0] lwv,
                      bit tv, int ts, int tw, bit fv, int fs, int fw);
    int pre, post;
    rst = r; lookup_valid = lv; lookup_set = 4'(ls); lookup_way_valid = lwv;
    touch_valid = tv; touch_set = 4'(ts); touch_way = 2'(tw);
    fill_valid = fv; fill_set = 4'(fs); fill_way = 2'(fw);
    pre = m_vic(ls, lwv);
    if (!r) begin
      if (tv) m_upd(ts, tw);
      if (fv) m_upd(fs, fw);
    end
    post = m_vic(ls, lwv);
    if (r) begin
      foreach (m_tree[s, n]) m_tree[s][n] = 1'b0;
      exp_vld = 1'b0;
      exp_way = 0;
    end else begin
      exp_vld = lv;
      if (lv) exp_way = FWD ? post : pre;
    end
    @(posedge clk);
    #1;
    chk("vvalid", int'(victim_valid), int'(exp_vld));
    chk("vway", int'(victim_way), exp_way);
  endtask

  task automatic idle();
    step(0, 0, 0, 4'hf, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 4'hf, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 4'hf, 1, 3, 1, 0, 0, 0);
    chk("rst_vvalid", int'(victim_valid), 0);
    chk("rst_vway", int'(victim_way), 0);

    // Fresh tree: all-valid lookup -> way 0
    step(0, 1, 3, 4'hf, 0, 0, 0, 0, 0, 0);
    chk("r034_vld", int'(victim_valid), 1);
    chk("r034_way", int'(victim_way), 0);
    idle();
    chk("r019_drop", int'(victim_valid), 0);
    chk("r020_hold", int'(victim_way), 0);

    // Touch way 0 -> victim 2; touch way 2 -> victim 1
    step(0, 0, 0, 4'hf, 1, 5, 0, 0, 0, 0);
    step(0, 1, 5, 4'hf, 0, 0, 0, 0, 0, 0);
    chk("r035_a", int'(victim_way), 2);
    step(0, 0, 0, 4'hf, 1, 5, 2, 0, 0, 0);
    step(0, 1, 5, 4'hf, 0, 0, 0, 0, 0, 0);
    chk("r035_b", int'(victim_way), 1);

    // Invalid way wins regardless of tree
    step(0, 1, 7, 4'b1011, 1, 7, 3, 0, 0, 0);
    chk("r036", int'(victim_way), 2);

    // Same-cycle touch then fill on one set; back-to-back lookups
    step(0, 0, 0, 4'hf, 1, 2, 1, 1, 2, 3);
    step(0, 1, 2, 4'hf, 0, 0, 0, 0, 0, 0);
    chk("r037", int'(victim_way), 0);
    step(0, 1, 5, 4'hf, 1, 4, 1, 1, 6, 2);
    chk("r023_b2b", int'(victim_way), 1);

    // Lookup racing a touch to the same set
    step(0, 1, 9, 4'hf, 1, 9, 0, 0, 0, 0);
    chk("r038", int'(victim_way), FWD ? 2 : 0);

    // Reset right after a lookup, then lookup a previously-touched set
    step(0, 1, 4, 4'hf, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 4'hf, 0, 0, 0, 1, 5, 0);
    chk("r039_vld", int'(victim_valid), 0);
    step(0, 1, 5, 4'hf, 0, 0, 0, 0, 0, 0);
    chk("r039_way", int'(victim_way), 0);

    // Random traffic; set/way fields are garbage whenever their valid is low
    for (int i = 0; i < 3000; i++) begin
      bit r, lv, tv, fv;
      int ls, ts, fs, nsets;
      logic [3:0] lwv;
      nsets = ($urandom_range(0, 1) == 0) ? 4 : SETS;
      r  = ($urandom_range(0, 199) == 0);
      lv = ($urandom_range(0, 2) != 0);
      tv = ($urandom_range(0, 1) == 0);
      fv = ($urandom_range(0, 2) == 0);
      ls = $urandom_range(0, nsets - 1);
      ts = $urandom_range(0, nsets - 1);
      fs = $urandom_range(0, nsets - 1);
      lwv = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hf;
      step(r, lv, ls, lwv, tv, ts, $urandom_range(0, WAYS - 1),
           fv, fs, $urandom_range(0, WAYS - 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_plru_array.md
CACHE_PLRU_ARRAY -- requirements
Module: cache_plru_array

Interface
REQ-001 SHALL have parameter WAYS, default 4: associativity; power of two, 2..32.
REQ-002 SHALL have parameter SETS, default 16: number of sets; power of two, >=2.
REQ-003 SHALL have ports clk input 1 (the single clock) and rst input 1 (synchronous, active-high reset).
REQ-004 SHALL have port lookup_valid input 1: request a victim for lookup_set.
REQ-005 SHALL have port lookup_set input $clog2(SETS): set index for the victim request.
REQ-006 SHALL have port lookup_way_valid input WAYS: valid bit of each way in lookup_set, sampled with lookup_valid.
REQ-007 SHALL have port touch_valid input 1: hit update.
REQ-008 SHALL have ports touch_set input $clog2(SETS) and touch_way input $clog2(WAYS): the set and way that hit.
REQ-009 SHALL have port fill_valid input 1: fill/prefetch install update.
REQ-010 SHALL have ports fill_set input $clog2(SETS) and fill_way input $clog2(WAYS): the set and way being installed.
REQ-011 SHALL have port victim_valid output 1: victim_way is the answer to the previous lookup.
REQ-012 SHALL have port victim_way output $clog2(WAYS): way to replace.

Function
REQ-013 SHALL hold WAYS-1 tree bits per set, in heap order: node 0 is the root; node i has children 2i+1 and 2i+2; the leaves map to ways 0..WAYS-1 from left to right.
REQ-014 Victim walk SHALL start at the root, go left on bit 0 and right on bit 1, and end at a leaf, which is the victim.
REQ-015 Update of way w SHALL set every node on the path to w so it points away from w (1 if w is in the left subtree, else 0); nodes off the path SHALL be unchanged.
REQ-016 Updates SHALL take effect at the rising edge of the cycle in which touch_valid or fill_valid is high.
REQ-017 When touch and fill target the same set in one cycle, the touch SHALL be applied first and the fill second (fill is MRU).
REQ-018 When touch and fill target different sets in one cycle, both SHALL be applied in that cycle.
REQ-019 A lookup SHALL have 1-cycle latency: victim_valid is high exactly in the cycle after lookup_valid, and victim_way is registered.
REQ-020 victim_way SHALL hold its value until the next completed lookup.
REQ-021 If lookup_way_valid has any zero bit, the victim SHALL be the lowest-index invalid way; otherwise it SHALL be the tree victim.
REQ-022 The lookup SHALL NOT modify PLRU state; the caller issues an explicit fill.
REQ-023 Back-to-back lookups, one per cycle, SHALL be supported with no bubbles.
REQ-024 X on set or way inputs while their valid is low SHALL NOT corrupt state.

Reset
REQ-025 On rst, all tree bits of all sets SHALL be 0.
REQ-026 On rst, victim_valid SHALL be 0 and victim_way SHALL be 0.
REQ-027 A lookup in flight when rst is asserted SHALL be dropped; victim_valid SHALL be 0 in the cycle after reset.
REQ-028 Updates presented in a reset cycle SHALL be ignored.

Configuration
REQ-029 Macro PLRU_FWD_EN defined: a lookup whose set matches a same-cycle touch and/or fill SHALL see the post-update state (per REQ-017).
REQ-030 Macro PLRU_FWD_EN undefined: such a lookup SHALL see the pre-update state; updates are still applied.

Structure
REQ-031 Package cache_types SHALL hold the PLRU_WAYS and PLRU_SETS defaults and a typedef for the per-set tree-bit vector.
REQ-032 Sub-module plru_tree_logic (combinational) SHALL compute the victim walk and path update for one set; the top instantiates it for the lookup, touch and fill paths.
REQ-033 State storage SHALL be flops, an array of SETS by WAYS-1 bits.

Verification (WAYS=4, SETS=16)
REQ-034 Reset, then lookup set 3 with all ways valid -> next cycle victim_valid=1, victim_way=0.
REQ-035 Touch set 5 way 0, then lookup set 5 with all ways valid -> victim_way=2; then touch way 2 and look up -> victim_way=1.
REQ-036 Lookup set 7 with lookup_way_valid=4'b1011 -> victim_way=2, regardless of tree state.
REQ-037 Same cycle: touch set 2 way 1 and fill set 2 way 3, then lookup set 2 -> victim_way=0 (bits root=0, node1=0, node2=0).
REQ-038 Lookup set 9 in the same cycle as touch set 9 way 0 -> victim_way=2 with PLRU_FWD_EN, 0 without.
REQ-039 Assert rst in the cycle after a lookup -> victim_valid stays 0; a subsequent lookup of any set returns 0.
